// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the delayed memory responder.
package mem_responder_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [3:0]  age;
  } rsp_entry_t;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic in_err_window(logic [31:0] addr, logic [31:0] base,
                                         logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// In-order response queue; every entry ages once per cycle so the head can be
// released at a fixed latency after its push.
module mem_rsp_fifo import mem_responder_pkg::*; #(
  parameter int Depth = 2,
  parameter int CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  logic [31:0]     push_data,
  input  logic            push_err,
  input  logic            pop,
  output logic [31:0]     head_data,
  output logic            head_err,
  output logic [3:0]      head_age,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  rsp_entry_t      ent_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < Depth; i++) ent_q[i] <= '0;
    end else begin
      // Saturate so a long-idle slot never wraps back into the pop window.
      for (int i = 0; i < Depth; i++)
        if (ent_q[i].age != 4'hF) ent_q[i].age <= ent_q[i].age + 4'd1;
      if (push) begin
        ent_q[wr_q] <= '{data: push_data, err: push_err, age: 4'd0};
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_data = ent_q[rd_q].data;
  assign head_err  = ent_q[rd_q].err;
  assign head_age  = ent_q[rd_q].age;
  assign full      = (cnt_q == CntW'(Depth));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;

`ifndef SYNTHESIS
  a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && empty));
`endif

endmodule

// File: rtl/mem_responder_delay.sv
// Memory responder with programmable grant/response latency and an error window.
// Define MEM_RESP_RAND_STALL_EN to add LFSR-driven random grant stalls.
module mem_responder_delay import mem_responder_pkg::*; #(
  parameter int          Depth          = 16384,
  parameter int          MaxOutstanding = 2,
  parameter int          GntDelay       = 0,
  parameter int          RspDelay       = 1,
  parameter logic [31:0] ErrAddrBase    = 32'hFFFF_F000,
  parameter logic [31:0] ErrAddrMask    = 32'hFFFF_F000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW   = $clog2(Depth);
  localparam int CntW = (GntDelay > 0) ? $clog2(GntDelay + 1) : 1;
  localparam int OutW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] GntCnt = CntW'(GntDelay);

  logic [31:0]     mem [Depth];
  logic [AW-1:0]   idx;
  logic [CntW-1:0] cnt_q;
  logic [OutW-1:0] outstanding;
  logic [31:0]     push_data, head_data;
  logic [3:0]      head_age;
  logic            acc_err, stall, grant, pop, full, empty, head_err;

  assign idx     = addr_i[AW+1:2];
  assign acc_err = in_err_window(addr_i, ErrAddrBase, ErrAddrMask) ||
                   ({2'b00, addr_i[31:2]} >= 32'(Depth));

`ifdef MEM_RESP_RAND_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LfsrSeed;
    else         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0);
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Full blocks grant using the pre-pop count, even when the head leaves this cycle.
  assign grant = req_i && !stall && !full && (cnt_q == GntCnt);
  assign gnt_o = grant && rst_ni;

  // A stalled cycle keeps req high without a grant, so the count holds rather than clears.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                cnt_q <= '0;
    else if (!req_i || grant)   cnt_q <= '0;
    else if (cnt_q != GntCnt)   cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (grant && we_i && !acc_err)
      for (int b = 0; b < 4; b++)
        if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
  end

  assign push_data = (we_i || acc_err) ? 32'h0 : mem[idx];
  assign pop       = !empty && (head_age == 4'(RspDelay - 1));

  mem_rsp_fifo #(.Depth(MaxOutstanding), .CntW(OutW)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (grant),
    .push_data (push_data),
    .push_err  (acc_err),
    .pop       (pop),
    .head_data (head_data),
    .head_err  (head_err),
    .head_age  (head_age),
    .full      (full),
    .empty     (empty),
    .count     (outstanding)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= pop;
      rdata_o  <= pop ? head_data : 32'h0;
      err_o    <= pop && head_err;
    end
  end

`ifndef SYNTHESIS
  a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_i && !gnt_o) |=> (req_i && $stable(addr_i) && $stable(we_i)));
  a_out_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(outstanding) <= MaxOutstanding);
`endif

endmodule

// File: doc/mem_responder_delay.md
Name: mem_responder_delay

Overview:
- Device-side responder for the core-facing request/grant/rvalid memory protocol, i.e. the answering end of a core instruction or data port.
- Contains a word-addressed RAM with programmable grant and response latency, a bounded in-order queue of outstanding requests, and an error-address window.
- Used in simulation tops in place of the bus and RAM path, to stress the core's LSU and prefetch buffer with stalls and pipelined responses.

Parameters:
- Depth, 16384: RAM size in 32-bit words; power of 2.
- MaxOutstanding, 2: maximum granted-but-unanswered requests; range 1..8.
- GntDelay, 0: cycles req_i must be held high before gnt_o asserts; 0 means grant in the same cycle.
- RspDelay, 1: cycles from grant to rvalid_o; range 1..15.
- ErrAddrBase, 32'hFFFF_F000: base of the error window.
- ErrAddrMask, 32'hFFFF_F000: mask of the error window.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  request; held until granted
- gnt_o  out  1  request accepted this cycle
- addr_i  in  32  byte address; bits [1:0] ignored
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables for writes
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, one cycle per granted request
- rdata_o  out  32  read data; 0 for writes and errors
- err_o  out  1  error response, valid with rvalid_o

Behaviour:
- Reset: one clock, asynchronous active-low reset, named clk_i/rst_ni. While rst_ni is low: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, queue empty, stall counter 0. RAM contents are not reset.
- Grant counter:
  - Increments each cycle req_i=1 && !gnt_o, saturating at GntDelay.
  - Clears on grant or when req_i=0.
- gnt_o = req_i && (count >= GntDelay) && (outstanding < MaxOutstanding).
  - Combinational when GntDelay=0.
  - When full, grant is blocked even if a response pops in the same cycle.
- Error condition: addr_i matches the error window, i.e. (addr_i & ErrAddrMask) == ErrAddrBase, or addr_i[31:2] >= Depth.
- Access at grant:
  - Read: RAM word captured into the queue entry.
  - Write: byte lanes with be_i=1 updated at the grant clock edge; entry data = 0.
  - Error: no RAM write; entry err=1, data=0.
- Queue:
  - Entry = {data[31:0], err, age[3:0]}; age loads 0 on push and increments each cycle.
  - Head pops when age == RspDelay-1, giving rvalid_o exactly RspDelay cycles after the grant edge.
  - Responses are strictly in order.
  - Back-to-back grants produce back-to-back rvalid.
- Push and pop in the same cycle: outstanding count unchanged.
- Read-after-write to the same word, granted on consecutive cycles: the read returns the new data.
- rvalid_o, rdata_o and err_o are registered, and rdata_o is 0 whenever rvalid_o=0.
- Reset mid-transaction: outstanding responses are dropped; no rvalid after reset release.
- Assertions (simulation only):
  - req_i must not drop, and addr_i/we_i must not change, while req_i=1 && !gnt_o.
  - The queue must never overflow.

Optional Feature:
- Macro MEM_RESP_RAND_STALL_EN.
- Defined:
  - A 16-bit Galois LFSR (seed 16'hACE1, taps 16'hB400) advances every cycle.
  - When lfsr[1:0]==2'b00, gnt_o is additionally masked for that cycle.
  - The grant counter does not clear during a masked cycle.
- Undefined: no LFSR logic; grant timing is fully deterministic.

Decomposition:
- Package mem_responder_pkg:
  - rsp_entry_t struct (data, err, age).
  - Constants LfsrSeed and LfsrTaps.
  - Function in_err_window(addr, base, mask).
- Sub-module mem_rsp_fifo: parameterised in-order queue with push/pop/full/empty/count and head-age output.
- RAM storage stays inline in the responder.

Test Plan:
- Basic write/read: GntDelay=0, RspDelay=1; write 32'hDEADBEEF to 0x100 with be=4'hF, then read 0x100 -> gnt in the same cycle as req; rvalid one cycle later; rdata=32'hDEADBEEF, err=0.
- Byte enables: write 32'h11223344 with be=4'b0101 over 32'hFFFFFFFF -> read returns 32'hFF22FF44.
- Grant delay: GntDelay=3, req held -> gnt on the 4th cycle of req; dropping req after 2 cycles then reasserting -> gnt is again 3 cycles later.
- Full queue: MaxOutstanding=2, RspDelay=5, 3 back-to-back reads -> first two granted on consecutive cycles; third granted only after the cycle in which the first rvalid pops; 3 rvalids in order.
- Error window: read 0xFFFF_F004 and write 0xFFFF_F008 -> both give rvalid with err=1, rdata=0; subsequent reads of RAM show no corruption; out-of-range address Depth*4 also returns err=1.
- Reset mid-operation: 2 reads outstanding, rst_ni pulsed low -> all outputs 0 immediately; no rvalid after release; next read completes normally.
